// File: rtl/freq_period_meter.sv
// Frequency and period meter for a slow asynchronous square wave, in units of clk.
// Frequency = rising edges per gate window; period = clk cycles between consecutive rising edges.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | counters cleared, valids low, results hold last values
// S_MEASURE | gate window, edge count and period count all running
module freq_period_meter #(
   parameter int GATE_CYCLES = 50000000,
   parameter int COUNT_W     = 27,
   parameter int PER_W       = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               sig_in,
   output logic [COUNT_W-1:0] freq_count,
   output logic               freq_valid,
   output logic               freq_ovf,
   output logic [PER_W-1:0]   period_cycles,
   output logic               period_valid,
   output logic               period_ovf
);

   localparam int                 GATE_W    = $clog2(GATE_CYCLES);
   localparam logic [GATE_W-1:0]  GATE_LAST = GATE_W'(GATE_CYCLES - 1);
   localparam logic [COUNT_W-1:0] CNT_MAX   = '1;
   localparam logic [PER_W-1:0]   PER_MAX   = '1;
   localparam logic [PER_W-1:0]   PER_ONE   = PER_W'(1);

   typedef enum logic {
      S_IDLE    = 1'b0,
      S_MEASURE = 1'b1
   } state_t;

   state_t state_q, state_d;

   logic sync1_q, sync2_q, dly_q;
   logic rise;

   logic [GATE_W-1:0]  gate_cnt_q, gate_cnt_d;
   logic [COUNT_W-1:0] edge_cnt_q, edge_cnt_d;
   logic               edge_sat_q, edge_sat_d;
   logic [PER_W-1:0]   per_cnt_q, per_cnt_d;
   logic               armed_q, armed_d;

   logic [COUNT_W-1:0] freq_count_q, freq_count_d;
   logic               freq_valid_q, freq_valid_d;
   logic               freq_ovf_q, freq_ovf_d;
   logic [PER_W-1:0]   period_cycles_q, period_cycles_d;
   logic               period_valid_q, period_valid_d;
   logic               period_ovf_q, period_ovf_d;

   // Synchronizer and edge detector run in every state so detection latency is constant.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         dly_q   <= 1'b0;
      end else begin
         sync1_q <= sig_in;
         sync2_q <= sync1_q;
         dly_q   <= sync2_q;
      end
   end

   assign rise = sync2_q & ~dly_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= S_IDLE;
         gate_cnt_q      <= '0;
         edge_cnt_q      <= '0;
         edge_sat_q      <= 1'b0;
         per_cnt_q       <= '0;
         armed_q         <= 1'b0;
         freq_count_q    <= '0;
         freq_valid_q    <= 1'b0;
         freq_ovf_q      <= 1'b0;
         period_cycles_q <= '0;
         period_valid_q  <= 1'b0;
         period_ovf_q    <= 1'b0;
      end else begin
         state_q         <= state_d;
         gate_cnt_q      <= gate_cnt_d;
         edge_cnt_q      <= edge_cnt_d;
         edge_sat_q      <= edge_sat_d;
         per_cnt_q       <= per_cnt_d;
         armed_q         <= armed_d;
         freq_count_q    <= freq_count_d;
         freq_valid_q    <= freq_valid_d;
         freq_ovf_q      <= freq_ovf_d;
         period_cycles_q <= period_cycles_d;
         period_valid_q  <= period_valid_d;
         period_ovf_q    <= period_ovf_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (en)  state_d = S_MEASURE;
         S_MEASURE: if (!en) state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   // Counters only advance while staying in MEASURE; any other path clears them,
   // so a dropped enable discards the partial window and disarms the period path.
   always_comb begin
      gate_cnt_d      = '0;
      edge_cnt_d      = '0;
      edge_sat_d      = 1'b0;
      per_cnt_d       = '0;
      armed_d         = 1'b0;
      freq_count_d    = freq_count_q;
      freq_valid_d    = 1'b0;
      freq_ovf_d      = freq_ovf_q;
      period_cycles_d = period_cycles_q;
      period_valid_d  = 1'b0;
      period_ovf_d    = period_ovf_q;

      if (state_q == S_MEASURE && en) begin
         if (gate_cnt_q == GATE_LAST) begin
            freq_valid_d = 1'b1;
            if (rise && edge_cnt_q == CNT_MAX) begin
               freq_count_d = CNT_MAX;
               freq_ovf_d   = 1'b1;
            end else begin
               freq_count_d = edge_cnt_q + COUNT_W'(rise);
               freq_ovf_d   = edge_sat_q;
            end
         end else begin
            gate_cnt_d = gate_cnt_q + GATE_W'(1);
            edge_cnt_d = edge_cnt_q;
            edge_sat_d = edge_sat_q;
            if (rise) begin
               if (edge_cnt_q == CNT_MAX) edge_sat_d = 1'b1;
               else                       edge_cnt_d = edge_cnt_q + COUNT_W'(1);
            end
         end

         if (rise) begin
            armed_d   = 1'b1;
            per_cnt_d = PER_ONE;
            if (armed_q) begin
               period_cycles_d = per_cnt_q;
               period_ovf_d    = (per_cnt_q == PER_MAX);
               period_valid_d  = 1'b1;
            end
         end else if (armed_q) begin
            armed_d   = 1'b1;
            per_cnt_d = (per_cnt_q == PER_MAX) ? PER_MAX : per_cnt_q + PER_W'(1);
         end
      end
   end

   assign freq_count    = freq_count_q;
   assign freq_valid    = freq_valid_q;
   assign freq_ovf      = freq_ovf_q;
   assign period_cycles = period_cycles_q;
   assign period_valid  = period_valid_q;
   assign period_ovf    = period_ovf_q;

endmodule

// File: tb/tb_freq_period_meter.sv
// Directed bench for freq_period_meter: three instances (default widths, narrow edge
// counter, narrow period counter) share clk/rst/en and see their own square waves.
module tb_freq_period_meter;

   localparam int GATE = 1000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic en  = 1'b0;
   logic man_a = 1'b0;
   logic sig_a, sig_c, sig_p;
   logic wave [3];
   int   per  [3] = '{0, 0, 0};
   int   ph   [3];
   int   cyc = 0;
   int   pv_cnt_a = 0;
   int   n_vec = 0;
   int   n_err = 0;

   logic [26:0] fc_a;  logic fv_a, fo_a;  logic [31:0] pc_a;  logic pv_a, po_a;
   logic [2:0]  fc_c;  logic fv_c, fo_c;  logic [31:0] pc_c;  logic pv_c, po_c;
   logic [26:0] fc_p;  logic fv_p, fo_p;  logic [5:0]  pc_p;  logic pv_p, po_p;

   freq_period_meter #(.GATE_CYCLES(GATE), .COUNT_W(27), .PER_W(32)) dut_a (
      .clk(clk), .rst(rst), .en(en), .sig_in(sig_a),
      .freq_count(fc_a), .freq_valid(fv_a), .freq_ovf(fo_a),
      .period_cycles(pc_a), .period_valid(pv_a), .period_ovf(po_a));

   freq_period_meter #(.GATE_CYCLES(GATE), .COUNT_W(3), .PER_W(32)) dut_c (
      .clk(clk), .rst(rst), .en(en), .sig_in(sig_c),
      .freq_count(fc_c), .freq_valid(fv_c), .freq_ovf(fo_c),
      .period_cycles(pc_c), .period_valid(pv_c), .period_ovf(po_c));

   freq_period_meter #(.GATE_CYCLES(GATE), .COUNT_W(27), .PER_W(6)) dut_p (
      .clk(clk), .rst(rst), .en(en), .sig_in(sig_p),
      .freq_count(fc_p), .freq_valid(fv_p), .freq_ovf(fo_p),
      .period_cycles(pc_p), .period_valid(pv_p), .period_ovf(po_p));

   always #10 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc = cyc + 1;
   end

   initial forever begin
      @(negedge clk);
      if (pv_a) pv_cnt_a = pv_cnt_a + 1;
   end

   // Square-wave generators: per[k] clk cycles per period, 50/50; per[k]==0 holds low.
   initial begin
      for (int k = 0; k < 3; k++) begin
         ph[k]   = 0;
         wave[k] = 1'b0;
      end
      forever begin
         @(negedge clk);
         for (int k = 0; k < 3; k++) begin
            if (per[k] == 0) begin
               ph[k]   = 0;
               wave[k] = 1'b0;
            end else begin
               ph[k]   = (ph[k] + 1 >= per[k]) ? 0 : ph[k] + 1;
               wave[k] = (ph[k] < per[k] / 2);
            end
         end
      end
   end

   assign sig_a = (per[0] == 0) ? man_a : wave[0];
   assign sig_c = wave[1];
   assign sig_p = wave[2];

   task automatic chk(input string tag, input longint obs, input longint exp);
      n_vec = n_vec + 1;
      assert (obs === exp) else begin
         n_err = n_err + 1;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic ev(input int w);
      case (w)
         0:       return fv_a;
         1:       return pv_a;
         2:       return fv_c;
         3:       return pv_p;
         default: return 1'b0;
      endcase
   endfunction

   // Returns the cycle number at which event w is seen, or -1 if the budget runs out.
   task automatic wait_ev(input int w, input int budget, output int at);
      at = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (ev(w)) begin
            at = cyc;
            break;
         end
      end
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   initial begin
      int c0, at, at2, v, pv0;

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_fc_a", fc_a, 0);
      chk("rst_fv_a", fv_a, 0);
      chk("rst_pc_a", pc_a, 0);
      chk("rst_pv_a", pv_a, 0);
      chk("rst_fo_c", fo_c, 0);
      chk("rst_po_p", po_p, 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // signal held low: windows report 0, period never fires
      c0 = cyc;
      en = 1'b1;
      wait_ev(0, 1100, at);
      chk("first_fv_latency", at, c0 + 1001);
      chk("idle_sig_fc_a", fc_a, 0);
      chk("idle_sig_fo_a", fo_a, 0);
      wait_ev(0, 1100, at2);
      chk("fv_spacing", at2 - at, GATE);
      chk("idle_sig_fc_a2", fc_a, 0);
      chk("idle_sig_pv_cnt", pv_cnt_a, 0);
      chk("idle_sig_pc_a", pc_a, 0);

      // A: period 100; C: period 10 (edge count saturates); P: period 100 (period saturates)
      per[0] = 100;
      per[1] = 10;
      per[2] = 100;
      wait_ev(0, 1100, at);
      wait_ev(0, 1100, at);
      chk("sq100_fc_a", fc_a, 10);
      chk("sq100_fo_a", fo_a, 0);
      chk("sat_fc_c", fc_c, 7);
      chk("sat_fo_c", fo_c, 1);
      wait_ev(1, 200, at);
      chk("sq100_pc_a", pc_a, 100);
      chk("sq100_po_a", po_a, 0);
      wait_ev(1, 200, at2);
      chk("pv_spacing", at2 - at, 100);
      wait_ev(3, 200, at);
      chk("sat_pc_p", pc_p, 63);
      chk("sat_po_p", po_p, 1);

      // recover from saturation
      per[1] = 200;
      per[2] = 40;
      wait_ev(3, 200, at);
      wait_ev(3, 200, at);
      wait_ev(3, 200, at);
      chk("rec_pc_p", pc_p, 40);
      chk("rec_po_p", po_p, 0);
      wait_ev(2, 1100, at);
      wait_ev(2, 1100, at);
      chk("rec_fc_c", fc_c, 5);
      chk("rec_fo_c", fo_c, 0);

      // drop enable mid-window: no result while low, outputs hold
      wait_ev(0, 1100, v);
      wait_until(v + 500);
      en = 1'b0;
      wait_ev(0, 2000, at);
      chk("en_low_no_fv", at, -1);
      chk("en_low_hold_fc_a", fc_a, 10);
      chk("en_low_hold_pc_a", pc_a, 100);
      chk("en_low_hold_fc_c", fc_c, 5);

      // re-enable; manual edges: one to arm, one landing on the closing cycle
      per[0] = 0;
      man_a  = 1'b0;
      repeat (5) @(negedge clk);
      c0  = cyc;
      pv0 = pv_cnt_a;
      en  = 1'b1;
      wait_until(c0 + 100);
      man_a = 1'b1;
      wait_until(c0 + 300);
      man_a = 1'b0;
      chk("arm_no_pv", pv_cnt_a - pv0, 0);
      wait_until(c0 + 998);
      man_a = 1'b1;
      wait_until(c0 + 1000);
      chk("pre_close_fv", fv_a, 0);
      wait_until(c0 + 1001);
      chk("close_fv_a", fv_a, 1);
      chk("close_pv_a", pv_a, 1);
      chk("close_fc_a", fc_a, 2);
      chk("close_pc_a", pc_a, 898);
      chk("close_po_a", po_a, 0);
      @(negedge clk);
      chk("fv_one_cycle", fv_a, 0);
      chk("pv_one_cycle", pv_a, 0);

      // async reset mid-window clears outputs before the next clk edge
      wait_until(c0 + 1300);
      #2 rst = 1'b1;
      #1;
      chk("arst_fc_a", fc_a, 0);
      chk("arst_pc_a", pc_a, 0);
      chk("arst_fc_c", fc_c, 0);
      chk("arst_pc_p", pc_p, 0);
      #5 rst = 1'b0;
      c0 = cyc;
      wait_ev(0, 1100, at);
      chk("post_rst_fv_latency", at, c0 + 1001);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
